// File: rtl/noc_outport_vc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : noc_outport_vc_arbiter
//  Purpose  : Output-port scheduler for one direction of a 2-VC mesh router.
//             Shares one output link among NREQ input ports using round-robin
//             arbitration, per-VC wormhole locking and credit-based flow
//             control. One instance per router output port.
//  Ports    : clk, rst         - clock / asynchronous active-high reset
//             req/req_vc/head/tail/idata - per-requester flit offer
//             credit_ret[1:0]  - one credit returned per VC (downstream ack)
//             grant[NREQ-1:0]  - one-hot combinational consume strobe
//             odata/ovalid/ovch - registered output flit, valid and VC
//             ordy[1:0]        - VC has at least one credit
//             olck[1:0]        - VC locked to a packet owner
//             timeout          - one-cycle pulse on watchdog lock release
//  Options  : ARB_WATCHDOG_EN  - enables per-VC lock watchdog (TIMEOUT cycles);
//             when undefined, locks are held indefinitely and timeout is 0.
//  Revision : 1.0 - initial release
// ============================================================================
module noc_outport_vc_arbiter #(
    parameter int NREQ    = 5,
    parameter int DATA_W  = 35,
    parameter int CREDITS = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_vc,
    input  logic [NREQ-1:0]          head,
    input  logic [NREQ-1:0]          tail,
    input  logic [NREQ*DATA_W-1:0]   idata,
    input  logic [1:0]               credit_ret,
    output logic [NREQ-1:0]          grant,
    output logic [DATA_W-1:0]        odata,
    output logic                     ovalid,
    output logic                     ovch,
    output logic [1:0]               ordy,
    output logic [1:0]               olck,
    output logic                     timeout
);

    localparam int              c_IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int              c_CW       = $clog2(CREDITS + 1);
    localparam logic [c_CW-1:0] c_CRED_MAX = c_CW'(CREDITS);
    localparam logic [c_IW-1:0] c_LAST_REQ = c_IW'(NREQ - 1);

    // Per-VC state encoding
    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;

    logic [c_CW-1:0]   r_credits [2];
    logic [0:0]        r_state   [2];
    logic [c_IW-1:0]   r_owner   [2];
    logic [c_IW-1:0]   r_ptr;
    logic [DATA_W-1:0] r_odata;
    logic              r_ovalid;
    logic              r_ovch;
    logic              r_timeout;

    logic [NREQ-1:0]   w_elig;
    logic [NREQ-1:0]   w_grant;
    logic              w_gnt_valid;
    logic [c_IW-1:0]   w_gnt_idx;
    logic              w_gnt_vc;
    logic              w_gnt_tail;
    logic [DATA_W-1:0] w_gnt_data;
    logic [1:0]        w_vc_gnt;

    // ------------------------------------------------------------------------
    // Eligibility: a head may only open an idle VC; body/tail flits may only
    // continue the packet that currently owns the VC. Everything else stalls.
    // ------------------------------------------------------------------------
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_elig[i] = req[i] && (r_credits[req_vc[i]] != '0) &&
                        (((r_state[req_vc[i]] == c_ST_IDLE) && head[i]) ||
                         ((r_state[req_vc[i]] == c_ST_LOCKED) &&
                          (r_owner[req_vc[i]] == c_IW'(i)) && !head[i]));
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin pick: scan from the pointer, first eligible requester wins.
    // Reset gates the grant so nothing is consumed while rst is held.
    // ------------------------------------------------------------------------
    always_comb begin : p_arb
        int              idx;
        logic [c_IW-1:0] cand;
        w_grant     = '0;
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        w_gnt_vc    = 1'b0;
        w_gnt_tail  = 1'b0;
        w_gnt_data  = '0;
        w_vc_gnt    = '0;
        idx         = 0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            cand = idx[c_IW-1:0];
            if (!w_gnt_valid && !rst && w_elig[cand]) begin
                w_gnt_valid   = 1'b1;
                w_gnt_idx     = cand;
                w_gnt_vc      = req_vc[cand];
                w_gnt_tail    = tail[cand];
                w_gnt_data    = idata[cand*DATA_W +: DATA_W];
                w_grant[cand] = 1'b1;
            end
        end
        if (w_gnt_valid) begin
            w_vc_gnt[w_gnt_vc] = 1'b1;
        end
    end

`ifdef ARB_WATCHDOG_EN
    localparam int              c_WW      = $clog2(TIMEOUT + 1);
    localparam logic [c_WW-1:0] c_WD_LAST = c_WW'(TIMEOUT - 1);

    logic [c_WW-1:0] r_wd_cnt [2];
    logic [1:0]      w_wd_fire;

    // Fires on the cycle whose increment would reach TIMEOUT
    always_comb begin
        w_wd_fire = '0;
        for (int v = 0; v < 2; v++) begin
            w_wd_fire[v] = (r_state[v] == c_ST_LOCKED) && !w_vc_gnt[v] &&
                           (r_wd_cnt[v] == c_WD_LAST);
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
`endif

    // ------------------------------------------------------------------------
    // State, credits and output flit register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_odata   <= '0;
            r_ovalid  <= 1'b0;
            r_ovch    <= 1'b0;
            r_ptr     <= '0;
            r_timeout <= 1'b0;
            for (int v = 0; v < 2; v++) begin
                r_credits[v] <= c_CRED_MAX;
                r_state[v]   <= c_ST_IDLE;
                r_owner[v]   <= '0;
`ifdef ARB_WATCHDOG_EN
                r_wd_cnt[v]  <= '0;
`endif
            end
        end else begin
            if (w_gnt_valid) begin
                r_odata  <= w_gnt_data;
                r_ovalid <= 1'b1;
                r_ovch   <= w_gnt_vc;
                r_ptr    <= (w_gnt_idx == c_LAST_REQ) ? '0 : w_gnt_idx + 1'b1;
            end else begin
                r_ovalid <= 1'b0;
            end

`ifdef ARB_WATCHDOG_EN
            r_timeout <= |w_wd_fire;
`else
            r_timeout <= 1'b0;
`endif

            for (int v = 0; v < 2; v++) begin
                // Grant and return in the same cycle cancel out
                if (w_vc_gnt[v] && !credit_ret[v]) begin
                    r_credits[v] <= r_credits[v] - 1'b1;
                end else if (!w_vc_gnt[v] && credit_ret[v] &&
                             (r_credits[v] != c_CRED_MAX)) begin
                    r_credits[v] <= r_credits[v] + 1'b1;
                end

                // Eligibility guarantees an idle-VC grant is a head and a
                // locked-VC grant comes from the owner.
                if (r_state[v] == c_ST_IDLE) begin
                    if (w_vc_gnt[v] && !w_gnt_tail) begin
                        r_state[v] <= c_ST_LOCKED;
                        r_owner[v] <= w_gnt_idx;
                    end
                end else begin
                    if (w_vc_gnt[v] && w_gnt_tail) begin
                        r_state[v] <= c_ST_IDLE;
                    end
                end

`ifdef ARB_WATCHDOG_EN
                if (r_state[v] == c_ST_LOCKED) begin
                    if (w_vc_gnt[v]) begin
                        r_wd_cnt[v] <= '0;
                    end else if (w_wd_fire[v]) begin
                        r_wd_cnt[v] <= '0;
                        r_state[v]  <= c_ST_IDLE;
                    end else begin
                        r_wd_cnt[v] <= r_wd_cnt[v] + 1'b1;
                    end
                end else begin
                    r_wd_cnt[v] <= '0;
                end
`endif
            end
        end
    end

    assign grant   = w_grant;
    assign odata   = r_odata;
    assign ovalid  = r_ovalid;
    assign ovch    = r_ovch;
    assign timeout = r_timeout;
    assign ordy    = {(r_credits[1] != '0), (r_credits[0] != '0)};
    assign olck    = {(r_state[1] == c_ST_LOCKED), (r_state[0] == c_ST_LOCKED)};

endmodule
`default_nettype wire

// File: tb/tb_noc_outport_vc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_noc_outport_vc_arbiter
//  Purpose  : Self-checking bench for noc_outport_vc_arbiter. Directed
//             scenarios plus a randomized run against a packet-level model
//             (credit counts, lock owners, round-robin pointer).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_noc_outport_vc_arbiter;

    localparam int NREQ    = 5;
    localparam int DATA_W  = 35;
    localparam int CREDITS = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req, req_vc, head, tail;
    logic [NREQ*DATA_W-1:0] idata;
    logic [1:0]             credit_ret;
    logic [NREQ-1:0]        grant;
    logic [DATA_W-1:0]      odata;
    logic                   ovalid, ovch, timeout;
    logic [1:0]             ordy, olck;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int                m_cred [2];
    bit                m_lock [2];
    int                m_owner[2];
    int                m_ptr;
    logic              exp_ovalid, exp_ovch;
    logic [DATA_W-1:0] exp_odata;

    noc_outport_vc_arbiter #(
        .NREQ(NREQ), .DATA_W(DATA_W), .CREDITS(CREDITS), .TIMEOUT(255)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_vc(req_vc), .head(head),
        .tail(tail), .idata(idata), .credit_ret(credit_ret), .grant(grant),
        .odata(odata), .ovalid(ovalid), .ovch(ovch), .ordy(ordy),
        .olck(olck), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    task automatic m_reset();
        for (int v = 0; v < 2; v++) begin
            m_cred[v]  = CREDITS;
            m_lock[v]  = 1'b0;
            m_owner[v] = 0;
        end
        m_ptr      = 0;
        exp_ovalid = 1'b0;
        exp_ovch   = 1'b0;
        exp_odata  = '0;
    endtask

    // Returns the requester that should be granted, or -1
    function automatic int m_pick();
        for (int k = 0; k < NREQ; k++) begin
            int i;
            int v;
            i = (m_ptr + k) % NREQ;
            v = int'(req_vc[i]);
            if (req[i] && m_cred[v] > 0) begin
                if (!m_lock[v] && head[i]) return i;
                if (m_lock[v] && m_owner[v] == i && !head[i]) return i;
            end
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] m_vec(input int g);
        logic [NREQ-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic m_apply(input int g);
        for (int v = 0; v < 2; v++) begin
            bit d;
            d = (g >= 0) && (int'(req_vc[g]) == v);
            if (d && !credit_ret[v]) m_cred[v] = m_cred[v] - 1;
            else if (!d && credit_ret[v] && m_cred[v] < CREDITS) m_cred[v] = m_cred[v] + 1;
        end
        if (g >= 0) begin
            int v;
            v = int'(req_vc[g]);
            if (!m_lock[v] && head[g] && !tail[g]) begin
                m_lock[v]  = 1'b1;
                m_owner[v] = g;
            end else if (m_lock[v] && tail[g]) begin
                m_lock[v] = 1'b0;
            end
            exp_ovalid = 1'b1;
            exp_ovch   = req_vc[g];
            exp_odata  = idata[g*DATA_W +: DATA_W];
            m_ptr      = (g + 1) % NREQ;
        end else begin
            exp_ovalid = 1'b0;
        end
    endtask

    // Advance one clock with the model following along
    task automatic step();
        m_apply(m_pick());
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req = '0; req_vc = '0; head = '0; tail = '0; credit_ret = '0;
    endtask

    task automatic randomize_data();
        for (int i = 0; i < NREQ; i++)
            idata[i*DATA_W +: DATA_W] = DATA_W'({$urandom, $urandom});
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        // Offer an eligible flit while reset is held: it must not be granted
        req = 5'b00100; head = '1; tail = '1; req_vc = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++; if (grant !== '0) begin n_errors++; $display("FAIL reset_grant: got %b expected 00000", grant); end
        n_checks++; if (ovalid !== 1'b0) begin n_errors++; $display("FAIL reset_ovalid: got %b expected 0", ovalid); end
        n_checks++; if (odata !== '0) begin n_errors++; $display("FAIL reset_odata: got %h expected 0", odata); end
        n_checks++; if (ovch !== 1'b0) begin n_errors++; $display("FAIL reset_ovch: got %b expected 0", ovch); end
        n_checks++; if (ordy !== 2'b11) begin n_errors++; $display("FAIL reset_ordy: got %b expected 11", ordy); end
        n_checks++; if (olck !== 2'b00) begin n_errors++; $display("FAIL reset_olck: got %b expected 00", olck); end
        n_checks++; if (timeout !== 1'b0) begin n_errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        clear_inputs();
        rst = 1'b0;
        m_reset();
        #1;
    endtask

    task automatic test_single_flit();
        logic [DATA_W-1:0] d;
        randomize_data();
        req = 5'b00100; head = 5'b00100; tail = 5'b00100; req_vc = '0;
        d = idata[2*DATA_W +: DATA_W];
        #1;
        n_checks++; if (grant !== 5'b00100) begin n_errors++; $display("FAIL single_grant: got %b expected 00100", grant); end
        step();
        req = '0;
        n_checks++; if (ovalid !== 1'b1) begin n_errors++; $display("FAIL single_ovalid: got %b expected 1", ovalid); end
        n_checks++; if (ovch !== 1'b0) begin n_errors++; $display("FAIL single_ovch: got %b expected 0", ovch); end
        n_checks++; if (odata !== d) begin n_errors++; $display("FAIL single_odata: got %h expected %h", odata, d); end
        n_checks++; if (olck !== 2'b00) begin n_errors++; $display("FAIL single_olck: got %b expected 00", olck); end
        step();
        n_checks++; if (ovalid !== 1'b0 || odata !== d) begin n_errors++; $display("FAIL single_hold: got ovalid=%b odata=%h expected ovalid=0 odata=%h", ovalid, odata, d); end
    endtask

    task automatic test_round_robin();
        do_reset();
        req = '1; head = '1; tail = '1; req_vc = '1; credit_ret = 2'b10;
        for (int k = 0; k < 6; k++) begin
            logic [NREQ-1:0] e;
            e = '0;
            e[k % NREQ] = 1'b1;
            #1;
            n_checks++; if (grant !== e) begin n_errors++; $display("FAIL rr_grant_%0d: got %b expected %b", k, grant, e); end
            step();
        end
        n_checks++; if (ordy !== 2'b11) begin n_errors++; $display("FAIL rr_ordy: got %b expected 11", ordy); end
        clear_inputs();
    endtask

    task automatic test_wormhole();
        do_reset();
        randomize_data();
        // requester 1 opens a packet on vc0
        req = 5'b00010; head = 5'b00010; tail = '0; req_vc = '0;
        #1;
        n_checks++; if (grant !== 5'b00010) begin n_errors++; $display("FAIL worm_head_grant: got %b expected 00010", grant); end
        step();
        n_checks++; if (olck !== 2'b01) begin n_errors++; $display("FAIL worm_locked: got %b expected 01", olck); end
        // requester 1 body, requester 3 head on vc0 must stall
        req = 5'b01010; head = 5'b01000; tail = 5'b01000; req_vc = '0;
        #1;
        n_checks++; if (grant !== 5'b00010) begin n_errors++; $display("FAIL worm_body_grant: got %b expected 00010", grant); end
        step();
        // requester 3 on vc1 proceeds while vc0 is locked
        req = 5'b01000; head = 5'b01000; tail = 5'b01000; req_vc = 5'b01000;
        #1;
        n_checks++; if (grant !== 5'b01000) begin n_errors++; $display("FAIL worm_other_vc: got %b expected 01000", grant); end
        step();
        n_checks++; if (ovch !== 1'b1) begin n_errors++; $display("FAIL worm_other_ovch: got %b expected 1", ovch); end
        // requester 1 tail while requester 3 still waits on vc0
        req = 5'b01010; head = 5'b01000; tail = 5'b01010; req_vc = '0;
        #1;
        n_checks++; if (grant !== 5'b00010) begin n_errors++; $display("FAIL worm_tail_grant: got %b expected 00010", grant); end
        step();
        n_checks++; if (olck !== 2'b00) begin n_errors++; $display("FAIL worm_unlocked: got %b expected 00", olck); end
        req = 5'b01000;
        #1;
        n_checks++; if (grant !== 5'b01000) begin n_errors++; $display("FAIL worm_waiter_grant: got %b expected 01000", grant); end
        step();
        clear_inputs();
    endtask

    task automatic test_credit_exhaust();
        do_reset();
        req = 5'b00001; head = 5'b00001; tail = 5'b00001; req_vc = '0;
        for (int k = 0; k < CREDITS; k++) begin
            #1;
            n_checks++; if (grant !== 5'b00001) begin n_errors++; $display("FAIL cred_grant_%0d: got %b expected 00001", k, grant); end
            step();
        end
        n_checks++; if (ordy !== 2'b10) begin n_errors++; $display("FAIL cred_empty_ordy: got %b expected 10", ordy); end
        #1;
        n_checks++; if (grant !== '0) begin n_errors++; $display("FAIL cred_fifth_blocked: got %b expected 00000", grant); end
        // return one credit (count 0 -> 1), then grant and return together
        credit_ret = 2'b01;
        step();
        n_checks++; if (grant !== 5'b00001) begin n_errors++; $display("FAIL cred_simul_grant: got %b expected 00001", grant); end
        step();
        req = '0; credit_ret = '0;
        step();
        n_checks++; if (ordy !== 2'b11) begin n_errors++; $display("FAIL cred_hold_one: got %b expected 11", ordy); end
        req = 5'b00001;
        step();
        req = '0;
        n_checks++; if (ordy !== 2'b10) begin n_errors++; $display("FAIL cred_exactly_one: got %b expected 10", ordy); end
        // five returns from 0 must saturate at CREDITS
        credit_ret = 2'b01;
        for (int k = 0; k < CREDITS + 1; k++) step();
        credit_ret = '0;
        req = 5'b00001;
        for (int k = 0; k < CREDITS; k++) step();
        n_checks++; if (ordy !== 2'b10) begin n_errors++; $display("FAIL cred_saturate: got %b expected 10", ordy); end
        #1;
        n_checks++; if (grant !== '0) begin n_errors++; $display("FAIL cred_sat_blocked: got %b expected 00000", grant); end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        randomize_data();
        req = 5'b00100; head = 5'b00100; tail = '0; req_vc = '1;
        #1;
        n_checks++; if (grant !== 5'b00100) begin n_errors++; $display("FAIL arst_head_grant: got %b expected 00100", grant); end
        step();
        head = '0;
        step();
        step();
        n_checks++; if (olck !== 2'b10 || ordy !== 2'b11 || ovalid !== 1'b1) begin n_errors++; $display("FAIL arst_pre: got olck=%b ordy=%b ovalid=%b expected 10/11/1", olck, ordy, ovalid); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (olck !== 2'b00) begin n_errors++; $display("FAIL arst_olck: got %b expected 00", olck); end
        n_checks++; if (ordy !== 2'b11) begin n_errors++; $display("FAIL arst_ordy: got %b expected 11", ordy); end
        n_checks++; if (ovalid !== 1'b0) begin n_errors++; $display("FAIL arst_ovalid: got %b expected 0", ovalid); end
        n_checks++; if (grant !== '0) begin n_errors++; $display("FAIL arst_grant: got %b expected 00000", grant); end
        @(posedge clk);
        #1;
        clear_inputs();
        rst = 1'b0;
        m_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 500; n++) begin
            int g;
            req        = NREQ'($urandom);
            req_vc     = NREQ'($urandom);
            head       = NREQ'($urandom);
            tail       = NREQ'($urandom);
            credit_ret = 2'($urandom_range(0, 3) & $urandom_range(0, 3));
            randomize_data();
            #1;
            g = m_pick();
            n_checks++; if (grant !== m_vec(g)) begin n_errors++; $display("FAIL rand_grant_%0d: got %b expected %b", n, grant, m_vec(g)); end
            m_apply(g);
            @(posedge clk);
            #1;
            n_checks++;
            if (ovalid !== exp_ovalid || odata !== exp_odata || (exp_ovalid && ovch !== exp_ovch)) begin
                n_errors++;
                $display("FAIL rand_out_%0d: got v=%b vc=%b d=%h expected v=%b vc=%b d=%h", n, ovalid, ovch, odata, exp_ovalid, exp_ovch, exp_odata);
            end
            n_checks++;
            if (ordy !== {m_cred[1] > 0, m_cred[0] > 0} || olck !== {m_lock[1], m_lock[0]} || timeout !== 1'b0) begin
                n_errors++;
                $display("FAIL rand_state_%0d: got ordy=%b olck=%b to=%b expected ordy=%b olck=%b to=0", n, ordy, olck, timeout, {m_cred[1] > 0, m_cred[0] > 0}, {m_lock[1], m_lock[0]});
            end
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idata = '0;
        clear_inputs();
        m_reset();
        test_reset();
        test_single_flit();
        test_round_robin();
        test_wormhole();
        test_credit_exhaust();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
